// File: rtl/fp_unit_dispatcher.sv
// Issues core FP requests to one unit and buffers its results in a credit-checked FIFO.
// Optional macro FP_DISP_BYPASS_EN forwards a result straight to R* when the FIFO is empty.
package apu_cluster_package;
    parameter int FP_WIDTH = 32;
endpackage

module fp_unit_dispatcher
    import apu_cluster_package::*;
#(
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = 5,
    parameter int RND_WIDTH  = 3,
    parameter int STAT_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  Req_i,
    output logic                  Gnt_o,
    input  logic [FP_WIDTH-1:0]   OpA_i,
    input  logic [FP_WIDTH-1:0]   OpB_i,
    input  logic [TAG_WIDTH-1:0]  Tag_i,
    input  logic [RND_WIDTH-1:0]  Rnd_i,
    output logic                  UnitEn_o,
    output logic [FP_WIDTH-1:0]   UnitOpA_o,
    output logic [FP_WIDTH-1:0]   UnitOpB_o,
    output logic [TAG_WIDTH-1:0]  UnitTag_o,
    output logic [RND_WIDTH-1:0]  UnitRnd_o,
    input  logic                  UnitReady_i,
    input  logic                  UnitValid_i,
    input  logic [FP_WIDTH-1:0]   UnitRes_i,
    input  logic [TAG_WIDTH-1:0]  UnitTag_i,
    input  logic [STAT_WIDTH-1:0] UnitStatus_i,
    output logic                  UnitAck_o,
    input  logic                  Flush_i,
    output logic                  RValid_o,
    input  logic                  RReady_i,
    output logic [FP_WIDTH-1:0]   RRes_o,
    output logic [TAG_WIDTH-1:0]  RTag_o,
    output logic [STAT_WIDTH-1:0] RStatus_o,
    output logic                  Busy_o,
    output logic                  Err_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {S_RUN, S_FLUSH} state_e;

    typedef struct packed {
        logic [FP_WIDTH-1:0]   res;
        logic [TAG_WIDTH-1:0]  tag;
        logic [STAT_WIDTH-1:0] status;
    } res_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   inflight_q, inflight_d, count_q, count_d;
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic            err_q, err_d;
    res_t            mem_q [DEPTH];

    logic            run, credit, issue, ret_ok, push, pop, fifo_clr, bypass, fifo_vld;
    logic [CW:0]     used;
    res_t            unit_res, head;

    assign unit_res = '{res: UnitRes_i, tag: UnitTag_i, status: UnitStatus_i};
    assign head     = mem_q[rptr_q];
    assign run      = (state_q == S_RUN);
    assign fifo_vld = run & (count_q != '0);

    // Every grant reserves a FIFO slot, so a returning result can never be refused.
    assign used     = {1'b0, inflight_q} + {1'b0, count_q};
    assign credit   = used < (CW+1)'(DEPTH);
    assign issue    = run & ~Flush_i & Req_i & UnitReady_i & credit;

    // A same-cycle issue covers a zero-latency return; anything else at inflight 0 is spurious.
    assign ret_ok   = UnitValid_i & ((inflight_q != '0) | issue);
    assign fifo_clr = run & Flush_i;

`ifdef FP_DISP_BYPASS_EN
    assign bypass   = run & ~Flush_i & ret_ok & RReady_i & (count_q == '0);
`else
    assign bypass   = 1'b0;
`endif

    assign push     = ret_ok & run & ~Flush_i & ~bypass;
    assign pop      = fifo_vld & RReady_i;

    always_comb begin
        inflight_d = inflight_q + CW'(issue) - CW'(ret_ok);
        err_d      = err_q | (UnitValid_i & ~ret_ok);
        if (fifo_clr) begin
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
            wptr_d  = wptr_q + PW'(push);
            rptr_d  = rptr_q + PW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_RUN;
            inflight_q <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= unit_res;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (Flush_i && inflight_d != '0) state_d = S_FLUSH;
            S_FLUSH: if (inflight_q == '0) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        Gnt_o     = issue;
        UnitEn_o  = issue;
        UnitOpA_o = issue ? OpA_i : '0;
        UnitOpB_o = issue ? OpB_i : '0;
        UnitTag_o = issue ? Tag_i : '0;
        UnitRnd_o = issue ? Rnd_i : '0;
        UnitAck_o = UnitValid_i;
        RValid_o  = 1'b0;
        RRes_o    = '0;
        RTag_o    = '0;
        RStatus_o = '0;
        if (bypass) begin
            RValid_o  = 1'b1;
            RRes_o    = UnitRes_i;
            RTag_o    = UnitTag_i;
            RStatus_o = UnitStatus_i;
        end else if (fifo_vld) begin
            RValid_o  = 1'b1;
            RRes_o    = head.res;
            RTag_o    = head.tag;
            RStatus_o = head.status;
        end
        Busy_o = (inflight_q != '0) | (count_q != '0);
        Err_o  = err_q;
    end

endmodule

// File: tb/tb_fp_unit_dispatcher.sv
// Directed bench for fp_unit_dispatcher; the bench plays the FP unit and a scoreboard checks drained results.
module tb_fp_unit_dispatcher;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        Req, Gnt, UnitEn, UnitReady, UnitValid, UnitAck, Flush, RValid, RReady, Busy, Err;
    logic [31:0] OpA, OpB, UnitOpA, UnitOpB, UnitRes, RRes;
    logic [4:0]  Tag, UnitTagO, UnitTagI, UnitStatus, RTag, RStatus;
    logic [2:0]  Rnd, UnitRnd;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        logic [4:0]  st;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    always #5 clk = ~clk;

    fp_unit_dispatcher dut (
        .clk_i(clk), .rst_ni(rst_n),
        .Req_i(Req), .Gnt_o(Gnt), .OpA_i(OpA), .OpB_i(OpB), .Tag_i(Tag), .Rnd_i(Rnd),
        .UnitEn_o(UnitEn), .UnitOpA_o(UnitOpA), .UnitOpB_o(UnitOpB), .UnitTag_o(UnitTagO),
        .UnitRnd_o(UnitRnd), .UnitReady_i(UnitReady), .UnitValid_i(UnitValid),
        .UnitRes_i(UnitRes), .UnitTag_i(UnitTagI), .UnitStatus_i(UnitStatus), .UnitAck_o(UnitAck),
        .Flush_i(Flush), .RValid_o(RValid), .RReady_i(RReady), .RRes_o(RRes), .RTag_o(RTag),
        .RStatus_o(RStatus), .Busy_o(Busy), .Err_o(Err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Unit returns a result for one cycle; keep=1 means it must later appear on R*.
    task automatic ret(input logic [4:0] t, input logic [31:0] r, input logic [4:0] s, input bit keep);
        UnitValid  = 1'b1;
        UnitTagI   = t;
        UnitRes    = r;
        UnitStatus = s;
        if (keep) sbq.push_back('{res: r, tag: t, st: s});
        #1 chk("unit_ack", UnitAck, 1);
        step();
        UnitValid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && RValid && RReady) begin
            exp_t e;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got tag %0d res %0h expected none", RTag, RRes);
            end else begin
                e = sbq.pop_front();
                chk("result", {RRes, RTag, RStatus}, e);
                pops++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int grants, p0;
        bit got;
        rst_n = 1'b0; Req = 0; OpA = 0; OpB = 0; Tag = 0; Rnd = 0; UnitReady = 0;
        UnitValid = 0; UnitRes = 0; UnitTagI = 0; UnitStatus = 0; Flush = 0; RReady = 0;
        #12;
        chk("rst_gnt", Gnt, 0);
        chk("rst_unit_en", UnitEn, 0);
        chk("rst_unit_opa", UnitOpA, 0);
        chk("rst_unit_tag", UnitTagO, 0);
        chk("rst_rvalid", RValid, 0);
        chk("rst_rres", RRes, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_err", Err, 0);
        step();
        rst_n = 1'b1;
        UnitReady = 1'b1;
        step();

        // single operation, unit latency 2
        Req = 1; OpA = 32'h3F80_0000; OpB = 32'h4000_0000; Tag = 3; Rnd = 2;
        #1;
        chk("single_gnt", Gnt, 1);
        chk("single_unit_en", UnitEn, 1);
        chk("single_unit_opa", UnitOpA, 32'h3F80_0000);
        chk("single_unit_opb", UnitOpB, 32'h4000_0000);
        chk("single_unit_tag", UnitTagO, 3);
        chk("single_unit_rnd", UnitRnd, 2);
        step();
        Req = 0;
        #1 chk("idle_unit_opa_zero", UnitOpA, 0);
        step();
        UnitValid = 1; UnitRes = 32'h4040_0000; UnitTagI = 3; UnitStatus = 5'h01;
        sbq.push_back('{res: 32'h4040_0000, tag: 5'd3, st: 5'h01});
        #1;
        chk("single_rvalid_same_cycle", RValid, 0);
        chk("single_ack", UnitAck, 1);
        step();
        UnitValid = 0;
        #1;
        chk("single_rvalid_next", RValid, 1);
        chk("single_rtag", RTag, 3);
        chk("single_busy", Busy, 1);
        RReady = 1;
        step();
        RReady = 0;
        #1;
        chk("single_drained", RValid, 0);
        chk("single_not_busy", Busy, 0);

        // backpressure: six requests, four credits
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            Req = 1; Tag = 5'(10 + i); OpA = 32'(i);
            #1 if (Gnt) grants++;
            step();
        end
        chk("bp_grants", grants, 4);
        #1 chk("bp_gnt_blocked", Gnt, 0);
        Req = 0;
        for (int i = 0; i < 4; i++) ret(5'(10 + i), 32'h1000 + 32'(i), 5'(i), 1);
        Req = 1;
        #1 chk("bp_gnt_fifo_full", Gnt, 0);
        chk("bp_rvalid", RValid, 1);
        chk("bp_head_tag", RTag, 10);
        Req = 0;
        RReady = 1;
        repeat (4) step();
        RReady = 0;
        #1 chk("bp_drained", RValid, 0);
        Req = 1; Tag = 21;
        #1 chk("bp_gnt_resume", Gnt, 1);
        step();
        Req = 0;
        ret(21, 32'h0000_5555, 5'h02, 1);
        RReady = 1;
        step();
        RReady = 0;
        #1 chk("bp_not_busy", Busy, 0);

        // zero-latency unit at full throughput
        p0 = pops; grants = 0; RReady = 1;
        for (int i = 0; i < 20; i++) begin
            Req = 1; Tag = 5'(i); OpA = 32'(i);
            UnitValid = 1; UnitTagI = 5'(i); UnitRes = 32'h2000 + 32'(i); UnitStatus = 5'(i);
            #1 if (Gnt) begin
                grants++;
                sbq.push_back('{res: 32'h2000 + 32'(i), tag: 5'(i), st: 5'(i)});
            end
            step();
        end
        Req = 0; UnitValid = 0;
        step();
        step();
        chk("zl_grants", grants, 20);
        chk("zl_results", pops - p0, 20);
        chk("zl_not_busy", Busy, 0);
        chk("zl_no_err", Err, 0);
        RReady = 0;

        // flush with two in flight and two buffered
        for (int i = 0; i < 4; i++) begin
            Req = 1; Tag = 5'(1 + i);
            #1 chk("fl_issue_gnt", Gnt, 1);
            step();
        end
        Req = 0;
        ret(1, 32'hDEAD_0001, 0, 0);
        ret(2, 32'hDEAD_0002, 0, 0);
        Flush = 1; Req = 1; Tag = 9;
        #1 chk("fl_gnt_flush_cycle", Gnt, 0);
        step();
        Flush = 0; RReady = 1;
        #1;
        chk("fl_rvalid_dropped", RValid, 0);
        chk("fl_gnt_flushing", Gnt, 0);
        ret(3, 32'hDEAD_0003, 0, 0);
        #1 chk("fl_gnt_one_left", Gnt, 0);
        ret(4, 32'hDEAD_0004, 0, 0);
        got = 0;
        for (int k = 0; k < 6 && !got; k++) begin
            #1 if (Gnt) got = 1;
            step();
        end
        Req = 0;
        chk("fl_gnt_after_flush", got, 1);
        ret(9, 32'h0000_0009, 5'h04, 1);
        step();
        RReady = 0;
        #1 chk("fl_not_busy", Busy, 0);
        chk("fl_no_err", Err, 0);

`ifdef FP_DISP_BYPASS_EN
        RReady = 1; Req = 1; Tag = 5;
        step();
        Req = 0;
        UnitValid = 1; UnitRes = 32'h3F80_0000; UnitTagI = 5; UnitStatus = 0;
        sbq.push_back('{res: 32'h3F80_0000, tag: 5'd5, st: 5'd0});
        #1;
        chk("byp_rvalid", RValid, 1);
        chk("byp_rres", RRes, 32'h3F80_0000);
        step();
        UnitValid = 0; RReady = 0;
        #1;
        chk("byp_fifo_empty", RValid, 0);
        chk("byp_not_busy", Busy, 0);
`endif

        // spurious return at idle
        UnitValid = 1; UnitTagI = 7; UnitRes = 32'h7777_7777; UnitStatus = 0;
        #1 chk("sp_ack", UnitAck, 1);
        step();
        UnitValid = 0;
        #1;
        chk("sp_err", Err, 1);
        chk("sp_rvalid", RValid, 0);
        step();
        step();
        chk("sp_err_sticky", Err, 1);
        rst_n = 0;
        #1 chk("sp_err_reset", Err, 0);
        step();
        rst_n = 1;
        step();

        chk("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_unit_dispatcher.md
# fp_unit_dispatcher

Initiator-side companion to the APU floating-point unit wrappers: accepts operation requests from a core-side req/gnt port, issues them to one FP unit (En/OpA/OpB/Tag/Rnd), and collects the unit's Valid/Res/Tag/Status returns into a result FIFO drained through a valid/ready port. Credit counting guarantees every issued operation has a reserved FIFO slot, so the unit's result is always accepted the cycle it appears. A flush state machine lets the cluster abandon outstanding work safely.

## Interface
- DEPTH, 4: result FIFO entries and max operations outstanding (in flight + buffered); power of two, ≥2
- TAG_WIDTH, 5: tag width
- RND_WIDTH, 3: rounding-mode width
- STAT_WIDTH, 5: status-flag width
- FP_WIDTH comes from apu_cluster_package (32)

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- Req_i  in  1  core request
- Gnt_o  out  1  request accepted this cycle
- OpA_i, OpB_i  in  FP_WIDTH  operands
- Tag_i  in  TAG_WIDTH  request tag
- Rnd_i  in  RND_WIDTH  rounding mode
- UnitEn_o  out  1  issue strobe to unit
- UnitOpA_o, UnitOpB_o  out  FP_WIDTH  operands to unit (zero when UnitEn_o=0)
- UnitTag_o  out  TAG_WIDTH  tag to unit
- UnitRnd_o  out  RND_WIDTH  rounding mode to unit
- UnitReady_i  in  1  unit can accept
- UnitValid_i  in  1  unit result valid
- UnitRes_i  in  FP_WIDTH  unit result
- UnitTag_i  in  TAG_WIDTH  unit result tag
- UnitStatus_i  in  STAT_WIDTH  unit status flags
- UnitAck_o  out  1  result accepted (= UnitValid_i)
- Flush_i  in  1  abandon all outstanding/buffered results
- RValid_o  out  1  result available
- RReady_i  in  1  consumer accepts result
- RRes_o, RTag_o, RStatus_o  out  FP_WIDTH/TAG_WIDTH/STAT_WIDTH  head result
- Busy_o  out  1  inflight>0 or FIFO non-empty
- Err_o  out  1  sticky: unit returned a result with nothing in flight

## Operation
- Counters: inflight (0..DEPTH), count (FIFO occupancy 0..DEPTH); invariant inflight+count ≤ DEPTH.
- FSM states RUN, FLUSH. Reset → RUN.
- RUN: Gnt_o = Req_i & UnitReady_i & (inflight+count < DEPTH); combinational. UnitEn_o = Gnt_o; unit fields pass through from core inputs.
- inflight += issue, −= UnitValid_i; both same cycle → unchanged (zero-latency unit).
- UnitValid_i pushes {Res,Tag,Status} into FIFO (RUN); UnitAck_o = UnitValid_i always.
- Pop on RValid_o & RReady_i; push and pop same cycle → count unchanged; pop when full with push → legal.
- RValid_o = count≠0; outputs show head entry, results returned in unit completion order.
- Flush_i in RUN: FIFO cleared next edge (count←0), Gnt_o forced 0 from that cycle; go FLUSH if inflight≠0 (after this cycle's update), else stay RUN.
- FLUSH: Gnt_o=0, RValid_o=0; arriving results acked and discarded, inflight decremented; return to RUN the cycle after inflight reaches 0. Flush_i in FLUSH ignored.
- UnitValid_i with inflight=0 and no same-cycle issue: result dropped, inflight held at 0, Err_o set until reset.

## Timing
- Reset values: Gnt_o 0, UnitEn_o 0, UnitOp*/Tag/Rnd 0, UnitAck_o 0, RValid_o 0, RRes_o/RTag_o/RStatus_o 0, Busy_o 0, Err_o 0; counters 0, FIFO pointers 0.
- Issue: zero cycles (request to UnitEn_o combinational).
- Return: UnitValid_i at edge N → RValid_o high after edge N (1 cycle).
- Full throughput: one issue and one return per cycle with RReady_i held high.
- Reset asserted mid-operation: all state cleared immediately; in-flight unit results after reset release raise Err_o.

## Configuration
- FP_DISP_BYPASS_EN defined: when FIFO empty, FSM in RUN, UnitValid_i=1 and RReady_i=1, result forwarded combinationally to R* outputs with RValid_o=1 in the same cycle, not written to FIFO. Undefined: all results go through the FIFO (1-cycle return latency); ports identical.

## Test plan
- Single op: Req_i with Tag 3, unit returns 2 cycles later → RValid_o one cycle after UnitValid_i, RTag_o=3, FIFO empties after RReady_i.
- Backpressure: RReady_i=0, issue 6 requests, DEPTH=4 → exactly 4 grants, Gnt_o=0 thereafter; release RReady_i → tags returned in order, grants resume.
- Zero-latency unit, Req_i and RReady_i held high 20 cycles → 20 grants, 20 results, inflight stays 0.
- Flush with 2 in flight, 2 buffered → RValid_o drops, Gnt_o 0 until both late results acked, then RUN; no flushed tag ever appears on RTag_o.
- Spurious UnitValid_i at idle → Err_o=1 sticky, RValid_o stays 0; rst_ni low clears Err_o.
- With FP_DISP_BYPASS_EN: empty FIFO, RReady_i=1, UnitValid_i with Res 0x3F800000 → RValid_o and RRes_o=0x3F800000 same cycle, count stays 0.
